// File: rtl/alu_pipe.sv
// Handshaked MIPS-32 style ALU with iterative MULTU/DIVU producing a HI result.
// Optional shifter (SLL/SRL/SRA) is built only when ALU_SHIFT_EN is defined.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zf,
    output logic             ovf,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_MULTU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL   = 4'd1;
    localparam logic [3:0] OP_SRL   = 4'd3;
    localparam logic [3:0] OP_SRA   = 4'd8;
`endif

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] wr_hi;
    logic [WIDTH-1:0] wr_lo;

    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] c_res;
    logic [WIDTH-1:0] c_hi;
    logic             c_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign sum      = a + b;
    assign diff     = a - b;

    always_comb begin
        c_res = '0;
        c_hi  = '0;
        c_ovf = 1'b0;
        case (alu_op)
            OP_ADD: begin
                c_res = sum;
                c_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_res = diff;
                c_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  c_res = a & b;
            OP_OR:   c_res = a | b;
            OP_XOR:  c_res = a ^ b;
            OP_NOR:  c_res = ~(a | b);
            OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // Only the divide-by-zero case of DIVU completes in one cycle.
            OP_DIVU: begin
                c_res = '1;
                c_hi  = a;
                c_ovf = 1'b1;
            end
`ifdef ALU_SHIFT_EN
            OP_SLL:  c_res = a << b[SHW-1:0];
            OP_SRL:  c_res = a >> b[SHW-1:0];
            OP_SRA:  c_res = $unsigned($signed(a) >>> b[SHW-1:0]);
`endif
            default: ;
        endcase
    end

    // MUL: {wr_hi,wr_lo} is the shift-right product register, multiplier in wr_lo.
    // DIV: wr_hi is the partial remainder, wr_lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum  = {1'b0, wr_hi} + (wr_lo[0] ? {1'b0, opb} : '0);
        div_sh   = {wr_hi, wr_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb};
        div_ok   = !div_diff[WIDTH];
        if (state == MUL) begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], wr_lo[WIDTH-1:1]};
        end else begin
            it_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            it_lo = {wr_lo[WIDTH-2:0], div_ok};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opb       <= '0;
            wr_hi     <= '0;
            wr_lo     <= '0;
            result    <= '0;
            hi        <= '0;
            zf        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (alu_op == OP_MULTU || (alu_op == OP_DIVU && b != '0)) begin
                state     <= (alu_op == OP_MULTU) ? MUL : DIV;
                cnt       <= '0;
                opb       <= b;
                wr_hi     <= '0;
                wr_lo     <= a;
                out_valid <= 1'b0;
            end else begin
                result    <= c_res;
                hi        <= c_hi;
                zf        <= (c_res == '0);
                ovf       <= c_ovf;
                out_valid <= 1'b1;
            end
        end else if (state != IDLE) begin
            wr_hi <= it_hi;
            wr_lo <= it_lo;
            cnt   <= cnt + SHW'(1);
            if (cnt == '1) begin
                state     <= IDLE;
                result    <= it_lo;
                hi        <= it_hi;
                zf        <= (it_lo == '0);
                ovf       <= 1'b0;
                out_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32); expectations follow ALU_SHIFT_EN if defined.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zf;
    logic        ovf;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zf;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi), .zf(zf), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      s;
        logic [63:0] p;
        e = '0;
        case (op)
            4'd0: begin
                s     = longint'($signed(x)) + longint'($signed(y));
                e.res = x + y;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: begin
                s     = longint'($signed(x)) - longint'($signed(y));
                e.res = x - y;
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4:  e.res = x & y;
            4'd5:  e.res = x | y;
            4'd6:  e.res = x ^ y;
            4'd7:  e.res = ~(x | y);
            4'd10: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd11: e.res = (x < y) ? 32'd1 : 32'd0;
            4'd12: begin
                p     = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
                e.hi  = p[63:32];
            end
            4'd13: begin
                if (y == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = x;
                    e.ovf = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                end
            end
`ifdef ALU_SHIFT_EN
            4'd1:  e.res = x << y[4:0];
            4'd3:  e.res = x >> y[4:0];
            4'd8:  e.res = $unsigned($signed(x) >>> y[4:0]);
`endif
            default: ;
        endcase
        e.zf = (e.res == 32'd0);
        return e;
    endfunction

    // Consumption happens at the next rising edge; out_ready only changes just after an edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", {32'd0, result}, {32'd0, e.res});
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("zf", {63'd0, zf}, {63'd0, e.zf});
                chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int acc);
        acc      = -1;
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                q.push_back(model(op, x, y));
                #1;
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int c0, c1, c2, c3;
        logic [3:0] ops[15] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11,
                                4'd12, 4'd13, 4'd1, 4'd3, 4'd8, 4'd9, 4'd15};
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_op = '0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_outs", {result, hi}, 64'd0);
        chk("rst_flags", {60'd0, zf, ovf, out_valid, busy}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(4'd0, 32'd12, 32'd12, c0);
        chk("add_valid_next", {63'd0, out_valid}, 64'd1);
        send(4'd0, 32'h7FFF_FFFF, 32'd1, c0);
        send(4'd2, 32'd12, 32'd12, c0);
        send(4'd10, 32'hFFFF_FFFF, 32'd1, c0);
        send(4'd11, 32'hFFFF_FFFF, 32'd1, c0);
        send(4'd7, 32'd0, 32'd0, c0);
        send(4'd2, 32'h8000_0000, 32'd1, c0);
        send(4'd14, 32'h1234_5678, 32'd9, c0);
        send(4'd8, 32'h8000_0000, 32'd4, c0);
        send(4'd1, 32'd1, 32'd31, c0);
        send(4'd3, 32'hF000_0000, 32'd8, c0);
        drain();

        send(4'd12, 32'hFFFF_FFFF, 32'd2, c0);
        for (int i = 0; i < 32; i++) begin
            chk("mul_busy", {62'd0, busy, in_ready}, 64'd2);
            chk("mul_no_valid", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
        end
        chk("mul_done", {62'd0, out_valid, busy}, 64'd2);
        drain();

        send(4'd13, 32'd25, 32'd12, c0);
        drain();
        send(4'd13, 32'd7, 32'd0, c0);
        chk("div0_single", {62'd0, out_valid, busy}, 64'd2);
        drain();

        for (int i = 0; i < 20; i++)
            send(ops[$urandom_range(0, 14)], $urandom, (i % 4 == 0) ? 32'd0 : $urandom, c0);
        drain();

        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd1, c0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_result", {32'd0, result}, 64'd2);
            chk("hold_valid", {62'd0, out_valid, in_ready}, 64'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        send(4'd5, 32'h0F0F_0000, 32'h0000_F0F0, c0);
        send(4'd6, 32'hAAAA_AAAA, 32'hFFFF_0000, c1);
        send(4'd4, 32'hFFFF_00FF, 32'h1234_5678, c2);
        send(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c3);
        chk("b2b_1", 64'(c1 - c0), 64'd1);
        chk("b2b_2", 64'(c2 - c1), 64'd1);
        chk("b2b_3", 64'(c3 - c2), 64'd1);
        drain();

        send(4'd12, 32'd1000, 32'd3, c0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_outs", {result, hi}, 64'd0);
        chk("arst_flags", {59'd0, zf, ovf, out_valid, busy, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'd0, 32'd3, 32'd4, c0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
